shift_arbiter: RTL

// - Shares one N-bit shift datapath between two requesters (req0: ALU shift ops, req1: immediate/CSR shift path).
// - Round-robin arbitration, valid/ready handshakes on both inputs and on the result port.
// - Registered result with requester tag, so consumers can demultiplex.
// - Sits between decode/issue and writeback in the pipelined core.
//

---
 rtl/shift_pkg.sv | 30 +++
 rtl/shift_arbiter_if.sv | 43 ++++
 rtl/rr_arb2.sv | 48 ++++
 rtl/shift_arbiter.sv | 71 +++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter slice: op encodings and the
// combinational shift function used by the shared datapath.
package shift_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = $clog2(DATA_W);

   typedef logic [1:0] shift_op_t;

   localparam shift_op_t SH_SRL  = 2'b00;
   localparam shift_op_t SH_SLL  = 2'b01;
   localparam shift_op_t SH_SRA  = 2'b10;
   localparam shift_op_t SH_PASS = 2'b11;

   // SRA goes through a signed view so the sign bit is replicated.
   function automatic logic [DATA_W-1:0] f_shift(input logic [DATA_W-1:0]  a,
                                                 input logic [SHAMT_W-1:0] shamt,
                                                 input shift_op_t          op);
      logic [DATA_W-1:0] r;
      r = a;
      case (op)
         SH_SRL:  r = a >> shamt;
         SH_SLL:  r = a << shamt;
         SH_SRA:  r = $unsigned($signed(a) >>> shamt);
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Requester / result bundle for the shared shift unit. The slave modport is
// the arbiter side; the master modport is the requesters plus the consumer.
interface shift_arbiter_if #(
   parameter int N   = 32,
   parameter int SHW = $clog2(N)
);

   logic           req0_valid;
   logic [N-1:0]   req0_a;
   logic [SHW-1:0] req0_shamt;
   logic [1:0]     req0_type;
   logic           req0_ready;

   logic           req1_valid;
   logic [N-1:0]   req1_a;
   logic [SHW-1:0] req1_shamt;
   logic [1:0]     req1_type;
   logic           req1_ready;

   logic           res_valid;
   logic [N-1:0]   res_data;
   logic           res_id;
   logic           res_ready;

   modport master (
      output req0_valid, req0_a, req0_shamt, req0_type,
      input  req0_ready,
      output req1_valid, req1_a, req1_shamt, req1_type,
      input  req1_ready,
      input  res_valid, res_data, res_id,
      output res_ready
   );

   modport slave (
      input  req0_valid, req0_a, req0_shamt, req0_type,
      output req0_ready,
      input  req1_valid, req1_a, req1_shamt, req1_type,
      output req1_ready,
      output res_valid, res_data, res_id,
      input  res_ready
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester favoured on a
// tie and only moves when the grant is actually consumed (advance).
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic valid0,
   input  logic valid1,
   input  logic advance,
   output logic grant0,
   output logic grant1
);

   logic ptr_q;
   logic ptr_d;

   // Pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // After a served grant, favour the other requester next time.
   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         ptr_d = grant0;
      end
   end

   // Grant decode: a lone requester always wins, ties go to the pointer.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      case ({valid1, valid0})
         2'b01:   grant0 = 1'b1;
         2'b10:   grant1 = 1'b1;
         2'b11: begin
            grant0 = ~ptr_q;
            grant1 = ptr_q;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one shift datapath between two requesters with round-robin grant
// and a one-entry registered result carrying the requester tag.
module shift_arbiter
   import shift_pkg::*;
#(
   parameter int N   = DATA_W,
   parameter int SHW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   shift_arbiter_if.slave bus
);

   logic           grant0;
   logic           grant1;
   logic           slot_free;
   logic           take0;
   logic           take1;
   logic           accept;

   logic [N-1:0]   sel_a;
   logic [SHW-1:0] sel_shamt;
   shift_op_t      sel_type;

   logic           res_valid_q;
   logic [N-1:0]   res_data_q;
   logic           res_id_q;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid0  (bus.req0_valid),
      .valid1  (bus.req1_valid),
      .advance (accept),
      .grant0  (grant0),
      .grant1  (grant1)
   );

   // The slot can refill in the same cycle the consumer drains it.
   assign slot_free = !res_valid_q | bus.res_ready;
   assign take0     = slot_free & grant0 & !rst;
   assign take1     = slot_free & grant1 & !rst;
   assign accept    = take0 | take1;

   assign bus.req0_ready = take0;
   assign bus.req1_ready = take1;

   assign sel_a     = grant1 ? bus.req1_a     : bus.req0_a;
   assign sel_shamt = grant1 ? bus.req1_shamt : bus.req0_shamt;
   assign sel_type  = grant1 ? bus.req1_type  : bus.req0_type;

   // Result register: data and tag only change on an accepted operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_id_q    <= 1'b0;
      end else if (accept) begin
         res_valid_q <= 1'b1;
         res_data_q  <= f_shift(sel_a, sel_shamt, sel_type);
         res_id_q    <= take1;
      end else if (bus.res_ready) begin
         res_valid_q <= 1'b0;
      end
   end

   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_id    = res_id_q;

endmodule
